// File: rtl/ok_arb_pkg.sv
// Shared types and helpers for the dual-host pipe arbiter.
// Imported by the arbiter top and its stall timer.
package ok_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    localparam logic SRC_P = 1'b0;
    localparam logic SRC_S = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ok_dual_pipe_arbiter_if.sv
// Bundle of both requester pipes plus the shared downstream pipe.
// slave is the arbiter view; master is the host/sink view.
interface ok_dual_pipe_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);

    logic              p_req;
    logic [LEN_W-1:0]  p_len;
    logic              p_valid;
    logic [DATA_W-1:0] p_data;
    logic              p_ready;
    logic              p_gnt;
    logic              p_done;
    logic              p_err;

    logic              s_req;
    logic [LEN_W-1:0]  s_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              s_gnt;
    logic              s_done;
    logic              s_err;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              m_sop;
    logic              m_eop;
    logic              m_src;
    logic              busy;

    modport slave (
        input  p_req, p_len, p_valid, p_data,
        output p_ready, p_gnt, p_done, p_err,
        input  s_req, s_len, s_valid, s_data,
        output s_ready, s_gnt, s_done, s_err,
        output m_valid, m_data, m_sop, m_eop, m_src,
        input  m_ready,
        output busy
    );

    modport master (
        output p_req, p_len, p_valid, p_data,
        input  p_ready, p_gnt, p_done, p_err,
        output s_req, s_len, s_valid, s_data,
        input  s_ready, s_gnt, s_done, s_err,
        input  m_valid, m_data, m_sop, m_eop, m_src,
        output m_ready,
        input  busy
    );

endinterface

// File: rtl/ok_burst_timer.sv
// Saturating stall counter; expired fires on the stall cycle
// that brings the count to TIMEOUT-1.
module ok_burst_timer
    import ok_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic okClk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] ARM  = W'(TIMEOUT - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = enable & (cnt == ARM);

endmodule

// File: rtl/ok_dual_pipe_arbiter.sv
// Round-robin burst arbiter sharing one downstream pipe between
// the primary and secondary host streams, with stall abort.
module ok_dual_pipe_arbiter
    import ok_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input logic okClk,
    input logic rst_n,
    ok_dual_pipe_arbiter_if.slave bus
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t            state;
    logic              src;
    logic              last_src;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  req_len;
    logic              p_gnt;
    logic              s_gnt;
    logic              p_done;
    logic              s_done;
    logic              err;
    logic              in_burst;
    logic              own_valid;
    logic [DATA_W-1:0] own_data;
    logic              xfer;
    logic              expired;
    logic              any_req;
    logic              pick_s;

    assign in_burst  = state == BURST;
    assign own_valid = src ? bus.s_valid : bus.p_valid;
    assign own_data  = src ? bus.s_data : bus.p_data;
    assign xfer      = in_burst & own_valid & bus.m_ready;
    assign any_req   = bus.p_req | bus.s_req;
    // Tie goes to whoever did not own the previous burst.
    assign pick_s    = bus.s_req & (~bus.p_req | last_src == SRC_P);
    assign req_len   = pick_s ? bus.s_len : bus.p_len;

    ok_burst_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .okClk   (okClk),
        .rst_n   (rst_n),
        .clear   (~in_burst | xfer),
        .enable  (in_burst & ~xfer),
        .expired (expired)
    );

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src      <= SRC_P;
            last_src <= SRC_S;
            cnt      <= '0;
            len_q    <= '0;
            p_gnt    <= 1'b0;
            s_gnt    <= 1'b0;
            p_done   <= 1'b0;
            s_done   <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        src      <= pick_s;
                        last_src <= pick_s;
                        cnt      <= req_len;
                        len_q    <= req_len;
                        p_gnt    <= ~pick_s;
                        s_gnt    <= pick_s;
                        if (req_len == '0) begin
                            state  <= DONE;
                            p_done <= ~pick_s;
                            s_done <= pick_s;
                        end else begin
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (xfer) begin
                        cnt <= cnt - ONE;
                        if (cnt == ONE) begin
                            state  <= DONE;
                            p_done <= ~src;
                            s_done <= src;
                        end
                    end else if (expired) begin
                        state  <= DONE;
                        p_done <= ~src;
                        s_done <= src;
                        err    <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    p_gnt  <= 1'b0;
                    s_gnt  <= 1'b0;
                    p_done <= 1'b0;
                    s_done <= 1'b0;
                    err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_gnt   = p_gnt;
    assign bus.s_gnt   = s_gnt;
    assign bus.p_done  = p_done;
    assign bus.s_done  = s_done;
    assign bus.p_err   = p_done & err;
    assign bus.s_err   = s_done & err;
    assign bus.m_valid = in_burst & own_valid;
    assign bus.m_data  = in_burst ? own_data : '0;
    assign bus.p_ready = in_burst & ~src & bus.m_ready;
    assign bus.s_ready = in_burst & src & bus.m_ready;
    assign bus.m_sop   = in_burst & (cnt == len_q);
    assign bus.m_eop   = in_burst & (cnt == ONE);
    assign bus.m_src   = src;
    assign bus.busy    = state != IDLE;

endmodule

// File: tb/tb_ok_dual_pipe_arbiter.sv
// Self-checking bench: vector table of single bursts plus tie,
// fairness and mid-burst reset sequences, with a word scoreboard.
module tb_ok_dual_pipe_arbiter;

    typedef struct {
        logic [31:0] data;
        bit          sop;
        bit          eop;
        bit          src;
    } exp_t;

    typedef struct {
        bit          side;
        int          len;
        logic [15:0] rpat;
        int          rlen;
        bit          exp_err;
        int          exp_words;
        int          exp_done;
    } vec_t;

    logic okClk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];
    vec_t vecs[7];

    ok_dual_pipe_arbiter_if #(.DATA_W(32), .LEN_W(16)) bus ();

    ok_dual_pipe_arbiter #(
        .DATA_W  (32),
        .LEN_W   (16),
        .TIMEOUT (8)
    ) dut (
        .okClk (okClk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit side, input int tag,
                                       input int k);
        logic [3:0] hi;
        hi = side ? 4'hB : 4'hA;
        return {hi, tag[11:0], k[15:0]};
    endfunction

    function automatic logic [12:0] outs();
        return {bus.p_ready, bus.p_gnt, bus.p_done, bus.p_err,
                bus.s_ready, bus.s_gnt, bus.s_done, bus.s_err,
                bus.m_valid, bus.m_sop, bus.m_eop, bus.m_src, bus.busy};
    endfunction

    always @(negedge okClk) begin
        if (rst_n && bus.m_valid)
            chk("other_ready", bus.m_src ? bus.p_ready : bus.s_ready, 0);
        if (rst_n && bus.m_valid && bus.m_ready) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("m_data", bus.m_data, e.data);
                chk("m_sop", bus.m_sop, e.sop);
                chk("m_eop", bus.m_eop, e.eop);
                chk("m_src", bus.m_src, e.src);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int tag);
        int  k;
        int  cyc;
        int  done_cyc;
        bit  got;
        bit  err;
        bit  eop_seen;
        for (int i = 0; i < v.exp_words; i++)
            sb.push_back('{data: mk(v.side, tag, i), sop: i == 0,
                           eop: i == v.len - 1, src: v.side});
        @(posedge okClk); #1;
        bus.p_req   = ~v.side;
        bus.s_req   = v.side;
        bus.p_len   = 16'(v.len);
        bus.s_len   = 16'(v.len);
        bus.m_ready = 1'b0;
        bus.p_valid = 1'b1;
        bus.s_valid = 1'b1;
        @(posedge okClk); #1;
        bus.p_req = 1'b0;
        bus.s_req = 1'b0;
        k = 0; cyc = 0; got = 0; err = 0; eop_seen = 0; done_cyc = -1;
        while (!got && cyc < 64) begin
            bus.m_ready = v.rpat[cyc % v.rlen];
            bus.p_data  = v.side ? 32'hDEAD_0000 : mk(0, tag, k);
            bus.s_data  = v.side ? mk(1, tag, k) : 32'hDEAD_0001;
            @(negedge okClk);
            if (cyc == 0) begin
                chk("gnt_latency", v.side ? bus.s_gnt : bus.p_gnt, 1);
                chk("gnt_other", v.side ? bus.p_gnt : bus.s_gnt, 0);
                chk("src_at_gnt", bus.m_src, v.side);
            end
            if (bus.m_valid && bus.m_eop) eop_seen = 1;
            if (bus.m_valid && bus.m_ready) k++;
            chk("other_done", v.side ? bus.p_done : bus.s_done, 0);
            if (v.side ? bus.s_done : bus.p_done) begin
                got = 1;
                done_cyc = cyc;
                err = v.side ? bus.s_err : bus.p_err;
            end
            if (!got) begin
                @(posedge okClk); #1;
                cyc++;
            end
        end
        chk("done_seen", got, 1);
        chk("done_cycle", done_cyc, v.exp_done);
        chk("done_err", err, v.exp_err);
        chk("words", k, v.exp_words);
        if (v.exp_err) chk("abort_no_eop", eop_seen, 0);
        @(posedge okClk); #1;
        bus.p_valid = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge okClk);
        chk("post_idle",
            {bus.busy, bus.p_gnt, bus.s_gnt, bus.p_done, bus.s_done}, 0);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    // Both sides request together; primary must win, then the
    // waiting secondary must win even while primary re-requests.
    task automatic tie(input int len, input int tag);
        int kp;
        int ks;
        int cyc;
        int n;
        bit ord[2];
        bit prev_p;
        bit prev_s;
        bit sdone;
        for (int i = 0; i < len; i++)
            sb.push_back('{data: mk(0, tag, i), sop: i == 0,
                           eop: i == len - 1, src: 1'b0});
        for (int i = 0; i < len; i++)
            sb.push_back('{data: mk(1, tag, i), sop: i == 0,
                           eop: i == len - 1, src: 1'b1});
        @(posedge okClk); #1;
        bus.p_req   = 1'b1;
        bus.s_req   = 1'b1;
        bus.p_len   = 16'(len);
        bus.s_len   = 16'(len);
        bus.m_ready = 1'b1;
        bus.p_valid = 1'b1;
        bus.s_valid = 1'b1;
        kp = 0; ks = 0; cyc = 0; n = 0;
        prev_p = 0; prev_s = 0; sdone = 0; ord = '{1'b1, 1'b0};
        while (!sdone && cyc < 40) begin
            bus.p_data = mk(0, tag, kp);
            bus.s_data = mk(1, tag, ks);
            @(negedge okClk);
            if (bus.p_gnt && !prev_p && n < 2) begin
                ord[n] = 1'b0;
                n++;
            end
            if (bus.s_gnt && !prev_s && n < 2) begin
                ord[n] = 1'b1;
                n++;
            end
            prev_p = bus.p_gnt;
            prev_s = bus.s_gnt;
            if (bus.p_valid && bus.p_ready) kp++;
            if (bus.s_valid && bus.s_ready) ks++;
            if (bus.s_done) sdone = 1;
            @(posedge okClk); #1;
            cyc++;
            if (bus.s_gnt) begin
                bus.p_req = 1'b0;
                bus.s_req = 1'b0;
            end
        end
        bus.p_req   = 1'b0;
        bus.s_req   = 1'b0;
        bus.p_valid = 1'b0;
        bus.s_valid = 1'b0;
        chk("tie_s_done", sdone, 1);
        chk("tie_grants", n, 2);
        chk("tie_first", ord[0], 0);
        chk("tie_second", ord[1], 1);
        chk("tie_words", kp + ks, 2 * len);
        chk("tie_sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic mid_reset();
        sb.push_back('{data: mk(0, 20, 0), sop: 1, eop: 0, src: 0});
        sb.push_back('{data: mk(0, 20, 1), sop: 0, eop: 0, src: 0});
        @(posedge okClk); #1;
        bus.p_req   = 1'b1;
        bus.p_len   = 16'd5;
        bus.m_ready = 1'b1;
        bus.p_valid = 1'b1;
        bus.s_valid = 1'b0;
        bus.p_data  = mk(0, 20, 0);
        @(posedge okClk); #1;
        bus.p_req = 1'b0;
        @(posedge okClk); #1;
        bus.p_data = mk(0, 20, 1);
        @(posedge okClk); #1;
        bus.p_data = mk(0, 20, 2);
        chk("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), 0);
        chk("mid_reset_data", bus.m_data, 0);
        chk("mid_reset_sb", sb.size(), 0);
        bus.p_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge okClk);
            chk("no_done_in_reset", {bus.p_done, bus.s_done}, 0);
        end
        rst_n = 1'b1;
        tie(1, 21);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vecs[0] = '{side: 0, len: 4, rpat: 16'hFFFF, rlen: 1,
                    exp_err: 0, exp_words: 4, exp_done: 4};
        vecs[1] = '{side: 1, len: 3, rpat: 16'h0029, rlen: 6,
                    exp_err: 0, exp_words: 3, exp_done: 6};
        vecs[2] = '{side: 0, len: 5, rpat: 16'h0000, rlen: 1,
                    exp_err: 1, exp_words: 0, exp_done: 7};
        vecs[3] = '{side: 0, len: 0, rpat: 16'hFFFF, rlen: 1,
                    exp_err: 0, exp_words: 0, exp_done: 0};
        vecs[4] = '{side: 1, len: 1, rpat: 16'hFFFF, rlen: 1,
                    exp_err: 0, exp_words: 1, exp_done: 1};
        vecs[5] = '{side: 0, len: 6, rpat: 16'h0001, rlen: 2,
                    exp_err: 0, exp_words: 6, exp_done: 11};
        vecs[6] = '{side: 1, len: 3, rpat: 16'h0001, rlen: 16,
                    exp_err: 1, exp_words: 1, exp_done: 8};

        rst_n       = 1'b0;
        bus.p_req   = 1'b1;
        bus.p_len   = 16'd3;
        bus.p_valid = 1'b1;
        bus.p_data  = 32'h1234_5678;
        bus.s_req   = 1'b0;
        bus.s_len   = 16'd0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'h0;
        bus.m_ready = 1'b1;
        #12;
        chk("reset_outs", outs(), 0);
        chk("reset_data", bus.m_data, 0);
        bus.p_req   = 1'b0;
        bus.p_valid = 1'b0;
        @(negedge okClk);
        rst_n = 1'b1;

        tie(2, 1);
        tie(2, 2);
        for (int vi = 0; vi < 7; vi++)
            run_vec(vecs[vi], vi + 3);
        mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
